// File: rtl/axi4_lite_req_arbiter.sv
// axi4_lite_req_arbiter: round-robin arbiter that shares one AXI4-lite master
// port between NB_REQ request/acknowledge requesters, one transaction at a time.
module axi4_lite_req_arbiter #(
  parameter int NB_REQ     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NB_REQ-1:0]              req_valid,
  input  logic [NB_REQ-1:0]              req_we,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NB_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NB_REQ-1:0]              req_ack,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  output logic                           req_err,
  output logic [NB_REQ-1:0]              grant,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [2:0]                     m_axi_awprot,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  input  logic [1:0]                     m_axi_bresp,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [2:0]                     m_axi_arprot,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp
);

  localparam int LW = $clog2(NB_REQ);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [NB_REQ-1:0] ONE_HOT0 = {{(NB_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                  state_reg;
  logic [LW-1:0]           last_reg;
  logic [NB_REQ-1:0]       grant_reg;
  logic [NB_REQ-1:0]       ack_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [SW-1:0]           wstrb_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;

  // Only bit 1 of the response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic unused_resp_lsb;
  assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

  // Per-requester payload slices, unpacked so the winner can be indexed.
  logic [ADDR_WIDTH-1:0] addr_arr  [NB_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NB_REQ];
  logic [SW-1:0]         wstrb_arr [NB_REQ];

  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[gi] = req_wstrb[gi*SW +: SW];
  end

  logic [LW-1:0] pick_idx;
  logic          pick_found;

  // Circular search from last+1: the first requesting index after the previous owner wins.
  always_comb begin
    logic [LW-1:0] idx;
    pick_idx   = '0;
    pick_found = 1'b0;
    idx        = last_reg;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = (idx == LW'(NB_REQ - 1)) ? '0 : idx + 1'b1;
      if (!pick_found && req_valid[idx]) begin
        pick_idx   = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= LW'(NB_REQ - 1);
      grant_reg   <= '0;
      ack_reg     <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= ONE_HOT0 << pick_idx;
            last_reg  <= pick_idx;
            addr_reg  <= addr_arr[pick_idx];
            wdata_reg <= wdata_arr[pick_idx];
            wstrb_reg <= wstrb_arr[pick_idx];
            if (req_we[pick_idx]) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently; move on once neither is outstanding.
          if (awvalid_reg && m_axi_awready) awvalid_reg <= 1'b0;
          if (wvalid_reg && m_axi_wready) wvalid_reg <= 1'b0;
          if ((!awvalid_reg || m_axi_awready) && (!wvalid_reg || m_axi_wready)) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_reg <= 1'b0;
            err_reg    <= m_axi_bresp[1];
            ack_reg    <= ONE_HOT0 << last_reg;
            state_reg  <= DONE;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid) begin
            rready_reg <= 1'b0;
            rdata_reg  <= m_axi_rdata;
            err_reg    <= m_axi_rresp[1];
            ack_reg    <= ONE_HOT0 << last_reg;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          grant_reg <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ack       = ack_reg;
  assign req_rdata     = rdata_reg;
  assign req_err       = err_reg;
  assign grant         = grant_reg;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Self-checking bench for axi4_lite_req_arbiter: a table of single transactions
// against a configurable-latency slave, then reset-in-flight and round-robin sequences.
module tb_axi4_lite_req_arbiter;

  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] req_valid, req_we;
  logic [NB*32-1:0] req_addr, req_wdata;
  logic [NB*4-1:0]  req_wstrb;
  logic [NB-1:0] req_ack, grant;
  logic [31:0]   req_rdata;
  logic          req_err;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]   m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
  logic [1:0]    m_axi_bresp, m_axi_rresp;

  axi4_lite_req_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err), .grant(grant),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    int          req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  // Slave model state: per-channel wait counts and handshake counts.
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int aw_c, w_c, b_c, ar_c, r_c;
  int aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] sl_base;
  logic [1:0]  sl_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic slave_cfg(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [31:0] base, input logic [1:0] resp);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    sl_base = base; sl_resp = resp;
  endtask

  // Drives slave inputs for the current cycle from the DUT's registered outputs.
  task automatic slave_drive();
    m_axi_awready = m_axi_awvalid && (aw_c >= aw_dly);
    if (m_axi_awvalid) begin if (m_axi_awready) aw_hs++; aw_c++; end
    m_axi_wready = m_axi_wvalid && (w_c >= w_dly);
    if (m_axi_wvalid) begin if (m_axi_wready) w_hs++; w_c++; end
    m_axi_bvalid = m_axi_bready && (b_c >= b_dly);
    m_axi_bresp  = sl_resp;
    if (m_axi_bready) begin if (m_axi_bvalid) b_hs++; b_c++; end
    m_axi_arready = m_axi_arvalid && (ar_c >= ar_dly);
    if (m_axi_arvalid) begin if (m_axi_arready) ar_hs++; ar_c++; end
    m_axi_rvalid = m_axi_rready && (r_c >= r_dly);
    m_axi_rdata  = sl_base + 32'(r_hs);
    m_axi_rresp  = sl_resp;
    if (m_axi_rready) begin if (m_axi_rvalid) r_hs++; r_c++; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    slave_drive();
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int   cyc;
    logic acked;
    logic [NB-1:0] own;
    own = NB'(1) << v.req;
    slave_cfg(v.aw_dly, v.w_dly, v.b_dly, v.ar_dly, v.r_dly, v.rdata, v.resp);
    // Other slices carry decoy payload so a wrong slice selection shows up.
    req_we    = ~{NB{v.we}};
    req_we[v.req] = v.we;
    req_addr  = {NB{32'hFFFF_FFF0}};
    req_addr[v.req*32 +: 32] = v.addr;
    req_wdata = {NB{~v.wdata}};
    req_wdata[v.req*32 +: 32] = v.wdata;
    req_wstrb = '0;
    req_wstrb[v.req*4 +: 4] = v.strb;
    req_valid = own;
    cyc = 0;
    acked = 1'b0;
    while (!acked && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 1) begin
        if (v.we) check("wr_valids_cyc1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        else      check("rd_valid_cyc1", m_axi_arvalid, 1'b1);
      end
      check("bready_only_in_resp", m_axi_bready && (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_rready), 1'b0);
      if (m_axi_awvalid && m_axi_awready) begin
        check("awaddr", m_axi_awaddr, v.addr);
        check("awprot", m_axi_awprot, 3'b000);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check("wdata", m_axi_wdata, v.wdata);
        check("wstrb", m_axi_wstrb, v.strb);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        check("araddr", m_axi_araddr, v.addr);
        check("arprot", m_axi_arprot, 3'b000);
      end
      if (|req_ack) begin
        acked = 1'b1;
        check("ack_owner", req_ack, own);
        check("ack_cycle", cyc, v.exp_cyc);
        check("grant_at_ack", grant, own);
        check("rdata", req_rdata, v.exp_rdata);
        check("err", req_err, v.exp_err);
        req_valid = '0;
      end
    end
    if (!acked) check("ack_timeout", 1'b0, 1'b1);
    if (v.we) begin
      check("aw_hs_count", aw_hs, 1);
      check("w_hs_count", w_hs, 1);
      check("b_hs_count", b_hs, 1);
    end else begin
      check("ar_hs_count", ar_hs, 1);
      check("r_hs_count", r_hs, 1);
    end
    step();
    check("ack_one_cycle", req_ack, 2'b00);
    check("grant_idle", grant, 2'b00);
    $display("vec %0d: %s req%0d addr=%h ack_cyc=%0d rdata=%h err=%0d",
             n, v.we ? "WR" : "RD", v.req, v.addr, cyc, req_rdata, req_err);
  endtask

  initial begin
    logic [NB-1:0] exp_seq [4];
    int n;
    int cyc;

    //        we    req addr    wdata         strb  rdata         resp   aw w  b  ar r  cyc exp_rdata     err
    vecs[0] = '{1'b0, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0,        2'b00, 0, 3, 0, 0, 0, 6, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 0, 32'h24, 32'h12345678, 4'h3, 32'h0,        2'b10, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b0, 1, 32'h30, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 0, 0, 0, 0, 0, 3, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 0, 32'h40, 32'h0F0F0F0F, 4'hC, 32'h0,        2'b00, 2, 0, 1, 0, 0, 6, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 1, 32'h44, 32'h0,        4'h0, 32'h0BADF00D, 2'b11, 0, 0, 0, 1, 2, 6, 32'h0BADF00D, 1'b1};

    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    slave_cfg(0, 0, 0, 0, 0, 32'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_ack", req_ack, 2'b00);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);
    check("rst_rdata", req_rdata, 32'h0);
    check("rst_err", req_err, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset while waiting in RD_RESP: everything drops at once, no ack follows.
    slave_cfg(0, 0, 0, 0, 20, 32'h5555_0000, 2'b00);
    req_we = '0;
    req_addr = {32'h0, 32'h50};
    req_valid = 2'b01;
    cyc = 0;
    while (!m_axi_rready && cyc < 10) begin
      step();
      cyc++;
    end
    check("reached_rd_resp", m_axi_rready, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_arvalid", m_axi_arvalid, 1'b0);
    check("midrst_rready", m_axi_rready, 1'b0);
    check("midrst_grant", grant, 2'b00);
    check("midrst_ack", req_ack, 2'b00);
    check("midrst_rdata", req_rdata, 32'h0);
    req_valid = '0;
    repeat (2) begin
      step();
      check("midrst_no_ack", req_ack, 2'b00);
    end
    rst = 1'b0;
    $display("reset during RD_RESP after %0d cycles: grant=%b ack=%b", cyc, grant, req_ack);

    // Both requesters read continuously; requester 0 must win first after reset.
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    slave_cfg(0, 0, 0, 0, 0, 32'h1000, 2'b00);
    req_we = '0;
    req_addr = {32'h200, 32'h100};
    req_valid = 2'b11;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      step();
      cyc++;
      req_valid = 2'b11;
      if (m_axi_arvalid && m_axi_arready)
        check("rr_araddr", m_axi_araddr, (grant == 2'b01) ? 32'h100 : 32'h200);
      if (|req_ack) begin
        check("rr_ack", req_ack, exp_seq[n]);
        check("rr_grant", grant, exp_seq[n]);
        check("rr_rdata", req_rdata, 32'h1000 + 32'(n));
        $display("rr txn %0d: grant=%b ack=%b rdata=%h cyc=%0d", n, grant, req_ack, req_rdata, cyc);
        req_valid = 2'b11 & ~req_ack;
        n++;
      end
    end
    if (n < 4) check("rr_timeout", n, 4);
    req_valid = '0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_req_arbiter.md
# axi4_lite_req_arbiter

Round-robin arbiter and sequencer that shares one AXI4-lite master port between `NB_REQ` simple request/acknowledge requesters, for example the CPU instruction-fetch and data paths plus a debug port. It sits between the requesters and the AXI4-lite interconnect of the zipcpu AXI4-lite top. It performs exactly one transaction at a time: it grants one requester, issues its read or write, waits for the response, and returns data and status with a one-cycle acknowledge.

## Interface
- `NB_REQ`, 2: number of requesters, minimum 2.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width, a multiple of 8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in NB_REQ: request from each requester. Held high, with its payload stable, until that requester's `req_ack` pulses.
- `req_we` in NB_REQ: 1 = write, 0 = read.
- `req_addr` in NB_REQ*ADDR_WIDTH: packed addresses; requester i uses slice i.
- `req_wdata` in NB_REQ*DATA_WIDTH: packed write data.
- `req_wstrb` in NB_REQ*DATA_WIDTH/8: packed byte strobes.
- `req_ack` out NB_REQ: one-cycle completion pulse, one-hot.
- `req_rdata` out DATA_WIDTH: read data, valid when any `req_ack` bit is high.
- `req_err` out 1: high with `req_ack` when the response code was SLVERR or DECERR.
- `grant` out NB_REQ: one-hot owner of the current transaction; 0 when IDLE.
- `m_axi_awvalid`/`awready`/`awaddr`/`awprot`: write-address channel (out/in/ADDR_WIDTH out/3 out).
- `m_axi_wvalid`/`wready`/`wdata`/`wstrb`: write-data channel.
- `m_axi_bvalid` in, `m_axi_bready` out, `m_axi_bresp` in 2: write-response channel.
- `m_axi_arvalid`/`arready`/`araddr`/`arprot`: read-address channel.
- `m_axi_rvalid` in, `m_axi_rready` out, `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2: read-data channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - If any `req_valid` is high, select the first set bit searching circularly from `last+1`, where `last` is the index of the previous grant.
  - Register `grant`, `last`, and the granted requester's we/addr/wdata/wstrb into internal registers.
  - Go to WR_REQ or RD_REQ.
- WR_REQ:
  - Assert `awvalid` and `wvalid` together.
  - Each is cleared independently on its own handshake (`valid & ready`). An AW and W handshake may occur in the same cycle or in either order.
  - When both channels are complete, go to WR_RESP.
- WR_RESP:
  - `bready` = 1.
  - On `bvalid`, capture `req_err` = `bresp[1]` and go to DONE.
- RD_REQ:
  - `arvalid` = 1.
  - On `arready`, go to RD_RESP.
- RD_RESP:
  - `rready` = 1.
  - On `rvalid`, capture `req_rdata` = `rdata` and `req_err` = `rresp[1]`, then go to DONE.
- DONE:
  - `req_ack[last]` = 1 for exactly one cycle. `grant` stays asserted.
  - Next state is IDLE.
  - `req_rdata` and `req_err` hold until the next capture.
- Payload outputs: `awaddr`/`araddr`/`wdata`/`wstrb` drive the latched registers. `awprot` and `arprot` are constant 3'b000.
- A requester must drop `req_valid` in the cycle after its ack; IDLE is therefore never entered with a stale request from the requester just served.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NB_REQ-1,0.
- Reset:
  - All AXI valid/ready outputs, `grant`, `req_ack`, `req_err` and `req_rdata` are 0.
  - `last` = NB_REQ-1, so requester 0 wins first.
  - State is IDLE.
  - Reset asserted mid-transaction abandons it with no ack; the interconnect is reset together with this block.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The request is sampled in IDLE at cycle 0. The AXI valid signals are high from cycle 1.
- Write, zero-wait slave (ready in cycle 1, `bvalid` in cycle 2): ack at cycle 3, IDLE at cycle 4. Throughput is 1 write per 4 cycles.
- Read, zero-wait slave (`arready` in cycle 1, `rvalid` in cycle 2): ack at cycle 3.
- Each wait cycle on any AXI channel adds exactly one cycle to the ack.
- Valid and payload signals remain stable while waiting for ready, per AXI.
- `req_valid` changes outside IDLE do not affect the transaction in flight.

## Test plan
- Single read, requester 0 at 0x0000_0010, zero-wait slave returning 0xDEADBEEF with OKAY -> `arvalid` at cycle 1, `req_ack`=01 at cycle 3, `req_rdata`=0xDEADBEEF, `req_err`=0.
- Write from requester 1 (0x20, 0xA5A5A5A5, strb 0xF), with `wready` delayed 3 cycles after `awready` -> `awvalid` drops after 1 cycle, `wvalid` after 4, ack at cycle 6, `bready` high only in WR_RESP.
- Both requesters hold reads continuously after reset -> grant sequence 01,10,01,10, with each ack matched to its owner.
- Write receiving SLVERR (bresp=2'b10) -> `req_ack` pulses with `req_err`=1. A following read with OKAY -> `req_err`=0.
- Reset asserted during RD_RESP -> `arvalid`, `rready`, `grant` and `req_ack` are 0 immediately with no ack. After release, requester 0 is granted first.
- AW and W ready in the same cycle, versus W ready before AW -> both orders reach WR_RESP, each channel handshakes exactly once.
